aoi_eval_arbiter: RTL and testbench

//  Shares one dual AND-OR evaluation unit among NUM_REQ requesters.
//  - p1y = a&b&c | d&e&f
//  - p2y = a&b | c&d

---
 rtl/aoi_pkg.sv | 31 +++
 rtl/aoi_rr_arbiter.sv | 52 +++++
 rtl/aoi_eval_arbiter.sv | 97 +++++++++
 tb/tb_aoi_eval_arbiter.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/aoi_pkg.sv
// Shared types and the dual AND-OR evaluation function for aoi_eval_arbiter.
package aoi_pkg;

   localparam int unsigned AOI_OP_W = 10;

   typedef struct packed {
      logic p1a;
      logic p1b;
      logic p1c;
      logic p1d;
      logic p1e;
      logic p1f;
      logic p2a;
      logic p2b;
      logic p2c;
      logic p2d;
   } aoi_op_t;

   typedef struct packed {
      logic p1y;
      logic p2y;
   } aoi_res_t;

   function automatic aoi_res_t aoi_eval(aoi_op_t op);
      aoi_res_t res;
      res.p1y = (op.p1a & op.p1b & op.p1c) | (op.p1d & op.p1e & op.p1f);
      res.p2y = (op.p2a & op.p2b) | (op.p2c & op.p2d);
      return res;
   endfunction

endpackage

// File: rtl/aoi_rr_arbiter.sv
// Round-robin grant over NUM_REQ requesters; the pointer moves past the winner on each issue.
module aoi_rr_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = 2
) (
   input  logic               clk,
   input  logic               areset_n,
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic               advance,
   output logic [NUM_REQ-1:0] win,
   output logic [ID_W-1:0]    win_idx,
   output logic               any_valid
);

   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

   always_comb begin
      int unsigned idx_int;
      logic [ID_W-1:0] idx;
      win       = '0;
      win_idx   = '0;
      any_valid = 1'b0;
      idx_int   = 0;
      idx       = '0;
      // Scan upward from the pointer with wrap; first valid bit wins.
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
         idx_int = (32'(rr_ptr_q) + off) % NUM_REQ;
         idx     = ID_W'(idx_int);
         if (!any_valid && req_valid[idx]) begin
            any_valid = 1'b1;
            win[idx]  = 1'b1;
            win_idx   = idx;
         end
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (advance && any_valid) begin
         rr_ptr_d = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + ID_W'(1);
      end
   end

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         rr_ptr_q <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end

endmodule

// File: rtl/aoi_eval_arbiter.sv
// Arbitrated shared AND-OR evaluator with a registered, backpressured result.
// Optional grant counter enabled by defining AOI_STATS_EN.
module aoi_eval_arbiter
   import aoi_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = 2,
   parameter int unsigned CNT_W   = 16
) (
   input  logic                        clk,
   input  logic                        areset_n,
   input  logic [NUM_REQ-1:0]          req_valid,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic [NUM_REQ*AOI_OP_W-1:0] req_op,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic                        rsp_p1y,
   output logic                        rsp_p2y,
   output logic [ID_W-1:0]             rsp_id
`ifdef AOI_STATS_EN
   ,
   output logic [CNT_W-1:0]            grant_count
`endif
);

   logic               issue_ok;
   logic               transfer;
   logic [NUM_REQ-1:0] win;
   logic [ID_W-1:0]    win_idx;
   logic               any_valid;
   aoi_op_t            ops [NUM_REQ];
   aoi_op_t            op_sel;
   aoi_res_t           res_q;
   logic               rsp_valid_q;
   logic [ID_W-1:0]    rsp_id_q;

   // Result slot is free when empty or being drained this cycle.
   assign issue_ok = !rsp_valid_q || rsp_ready;
   assign transfer = issue_ok && any_valid;

   aoi_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
      .clk       (clk),
      .areset_n  (areset_n),
      .req_valid (req_valid),
      .advance   (issue_ok),
      .win       (win),
      .win_idx   (win_idx),
      .any_valid (any_valid)
   );

   assign req_ready = issue_ok ? win : '0;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_ops
      assign ops[g] = aoi_op_t'(req_op[g*AOI_OP_W +: AOI_OP_W]);
   end
   assign op_sel = ops[win_idx];

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         rsp_valid_q <= 1'b0;
         res_q       <= '0;
         rsp_id_q    <= '0;
      end else if (transfer) begin
         rsp_valid_q <= 1'b1;
         res_q       <= aoi_eval(op_sel);
         rsp_id_q    <= win_idx;
      end else if (rsp_ready) begin
         rsp_valid_q <= 1'b0;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_p1y   = res_q.p1y;
   assign rsp_p2y   = res_q.p2y;
   assign rsp_id    = rsp_id_q;

`ifdef AOI_STATS_EN
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         cnt_q <= '0;
      end else if (transfer && (cnt_q != '1)) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign grant_count = cnt_q;
`else
   logic unused_cnt_w;
   assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_aoi_eval_arbiter.sv
// Directed self-checking bench for aoi_eval_arbiter; counter checks need AOI_STATS_EN.
module tb_aoi_eval_arbiter;

   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned ID_W    = 2;
   localparam int unsigned CNT_W   = 3;

   logic                 clk = 1'b0;
   logic                 areset_n;
   logic [NUM_REQ-1:0]   req_valid;
   logic [NUM_REQ-1:0]   req_ready;
   logic [NUM_REQ*10-1:0] req_op;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic                 rsp_p1y;
   logic                 rsp_p2y;
   logic [ID_W-1:0]      rsp_id;
`ifdef AOI_STATS_EN
   logic [CNT_W-1:0]     grant_count;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   aoi_eval_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W),
      .CNT_W   (CNT_W)
   ) dut (
      .clk         (clk),
      .areset_n    (areset_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_op      (req_op),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_p1y     (rsp_p1y),
      .rsp_p2y     (rsp_p2y),
      .rsp_id      (rsp_id)
`ifdef AOI_STATS_EN
      ,
      .grant_count (grant_count)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_rsp(input string tag, input logic v, input logic p1, input logic p2,
                          input logic [ID_W-1:0] id);
      chk({tag, ".valid"}, 32'(rsp_valid), 32'(v));
      chk({tag, ".p1y"}, 32'(rsp_p1y), 32'(p1));
      chk({tag, ".p2y"}, 32'(rsp_p2y), 32'(p2));
      chk({tag, ".id"}, 32'(rsp_id), 32'(id));
   endtask

   task automatic do_reset();
      areset_n  = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b1;
      repeat (2) @(negedge clk);
      areset_n = 1'b1;
   endtask

   logic [ID_W-1:0] fair_id [6];
   logic            fair_p1 [6];
   logic            fair_p2 [6];

   initial begin
      req_op    = 'x;
      fair_id   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      fair_p1   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      fair_p2   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

      do_reset();
      #1;
      chk_rsp("reset", 1'b0, 1'b0, 1'b0, 2'd0);
      chk("reset.req_ready", 32'(req_ready), 32'h0);
`ifdef AOI_STATS_EN
      chk("reset.count", 32'(grant_count), 32'h0);
`endif

      // Single request on req0; other operand slices are X.
      @(negedge clk);
      req_op[9:0] = 10'b111000_1100;
      req_valid   = 4'b0001;
      #1;
      chk("t1.req_ready", 32'(req_ready), 32'h1);
      @(negedge clk);
      chk_rsp("t1", 1'b1, 1'b1, 1'b1, 2'd0);

      // Second-term match on req2, then zero operands.
      req_op[29:20] = 10'b110111_0101;
      req_valid     = 4'b0100;
      #1;
      chk("t2.req_ready", 32'(req_ready), 32'h4);
      @(negedge clk);
      chk_rsp("t2a", 1'b1, 1'b1, 1'b0, 2'd2);
      req_op[29:20] = 10'b0;
      @(negedge clk);
      chk_rsp("t2b", 1'b1, 1'b0, 1'b0, 2'd2);
      req_valid = '0;
      @(negedge clk);
      chk("t2.drain", 32'(rsp_valid), 32'h0);

      // Fairness from pointer 0 with all requesters valid.
      do_reset();
      req_op[9:0]   = 10'b111000_1100;
      req_op[19:10] = 10'b0;
      req_op[29:20] = 10'b110111_0101;
      req_op[39:30] = 10'b000000_0011;
      req_valid     = 4'b1111;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk_rsp($sformatf("t3.%0d", k), 1'b1, fair_p1[k], fair_p2[k], fair_id[k]);
      end

      // Backpressure: result from req1 (op=0) frozen for 3 cycles.
      req_valid     = 4'b0010;
      req_op[19:10] = 10'b000000_1100;
      rsp_ready     = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("t4.req_ready%0d", k), 32'(req_ready), 32'h0);
         @(negedge clk);
         chk_rsp($sformatf("t4.hold%0d", k), 1'b1, 1'b0, 1'b0, 2'd1);
      end
      rsp_ready = 1'b1;
      #1;
      chk("t4.release_ready", 32'(req_ready), 32'h2);
      @(negedge clk);
      chk_rsp("t4.accept", 1'b1, 1'b0, 1'b1, 2'd1);

      // Grant req3 (pointer wraps), then reset while a result is pending.
      req_valid = 4'b1000;
      #1;
      chk("t5.req_ready3", 32'(req_ready), 32'h8);
      @(negedge clk);
      chk_rsp("t5.grant3", 1'b1, 1'b0, 1'b1, 2'd3);
      req_valid = 4'b1010;
      #2;
      areset_n = 1'b0;
      #1;
      chk("t5.async_drop", 32'(rsp_valid), 32'h0);
      @(negedge clk);
      @(negedge clk);
      areset_n = 1'b1;
      #1;
      chk("t5.first_ready", 32'(req_ready), 32'h2);
      @(negedge clk);
      chk("t5.first_id", 32'(rsp_id), 32'h1);
      @(negedge clk);
      chk("t5.second_id", 32'(rsp_id), 32'h3);

`ifdef AOI_STATS_EN
      // Counter saturates at all-ones (7 for CNT_W=3).
      do_reset();
      #1;
      chk("t6.zero", 32'(grant_count), 32'h0);
      req_valid = 4'b0001;
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         chk($sformatf("t6.count%0d", k), 32'(grant_count), (k < 7) ? 32'(k) : 32'h7);
      end
`endif
      req_valid = '0;
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
